wave_sequencer: RTL and testbench

//   Playlist controller for wave_generator. Holds a small table of entries {waveform, phase, amplitude, duration}.

---
 rtl/wave_seq_pkg.sv | 30 +++
 rtl/wave_seq_table.sv | 52 +++++
 rtl/wave_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_wave_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_seq_pkg.sv
// Shared types for the wave_generator playlist sequencer.
package wave_seq_pkg;

    // Sequencer states; "end of list" is a decision taken on FETCH/RUN exit, not a state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SET_PH = 3'd2,
        ST_SET_AM = 3'd3,
        ST_RUN    = 3'd4
    } state_e;

    // Waveform codes understood by wave_generator.
    localparam logic [1:0] WAVE_SINE     = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_SAW      = 2'd3;

    localparam int SEQ_DUR_W  = 16;
    localparam int SEQ_DATA_W = 8;

    // One playlist entry at the default widths.
    typedef struct packed {
        logic [1:0]            waveform;
        logic [SEQ_DATA_W-1:0] phase;
        logic [SEQ_DATA_W-1:0] amplitude;
        logic [SEQ_DUR_W-1:0]  duration;
    } entry_t;

endpackage

// File: rtl/wave_seq_table.sv
// Playlist storage: synchronous write, asynchronous read, cleared on reset.
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    parameter  int DUR_W       = SEQ_DUR_W,
    parameter  int DATA_W      = SEQ_DATA_W,
    localparam int ADDR_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [1:0]        wr_waveform_i,
    input  logic [DATA_W-1:0] wr_phase_i,
    input  logic [DATA_W-1:0] wr_amplitude_i,
    input  logic [DUR_W-1:0]  wr_duration_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [1:0]        rd_waveform_o,
    output logic [DATA_W-1:0] rd_phase_o,
    output logic [DATA_W-1:0] rd_amplitude_o,
    output logic [DUR_W-1:0]  rd_duration_o
);

    logic [1:0]        wf_q  [NUM_ENTRIES];
    logic [DATA_W-1:0] ph_q  [NUM_ENTRIES];
    logic [DATA_W-1:0] am_q  [NUM_ENTRIES];
    logic [DUR_W-1:0]  dur_q [NUM_ENTRIES];

    // Clear every entry on reset (zero duration = empty list), otherwise accept one write per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                wf_q[i]  <= '0;
                ph_q[i]  <= '0;
                am_q[i]  <= '0;
                dur_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            wf_q[wr_addr_i]  <= wr_waveform_i;
            ph_q[wr_addr_i]  <= wr_phase_i;
            am_q[wr_addr_i]  <= wr_amplitude_i;
            dur_q[wr_addr_i] <= wr_duration_i;
        end
    end

    assign rd_waveform_o  = wf_q[rd_addr_i];
    assign rd_phase_o     = ph_q[rd_addr_i];
    assign rd_amplitude_o = am_q[rd_addr_i];
    assign rd_duration_o  = dur_q[rd_addr_i];

endmodule

// File: rtl/wave_sequencer.sv
// Playlist controller driving wave_generator's config interface from a small entry table.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    parameter  int DUR_W       = SEQ_DUR_W,
    parameter  int DATA_W      = SEQ_DATA_W,
    localparam int ADDR_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [1:0]        wr_waveform_i,
    input  logic [DATA_W-1:0] wr_phase_i,
    input  logic [DATA_W-1:0] wr_amplitude_i,
    input  logic [DUR_W-1:0]  wr_duration_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic              sample_valid_i,
    output logic              enable_o,
    output logic [1:0]        waveform_o,
    output logic              set_phase_strobe_o,
    output logic              set_ampl_strobe_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] entry_idx_o,
    output logic              done_strobe_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d, dur_q, dur_d;
    logic [DATA_W-1:0] ph_q, ph_d, am_q, am_d;
    logic [1:0]        wf_q, wf_d;
    logic              finish;

    logic [1:0]        tbl_wf;
    logic [DATA_W-1:0] tbl_ph, tbl_am;
    logic [DUR_W-1:0]  tbl_dur;

    logic              enable_q, enable_d, phs_q, phs_d, ams_q, ams_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [1:0]        wave_q, wave_d;
    logic [DATA_W-1:0] data_q, data_d;

    wave_seq_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DUR_W       (DUR_W),
        .DATA_W      (DATA_W)
    ) u_table (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_waveform_i  (wr_waveform_i),
        .wr_phase_i     (wr_phase_i),
        .wr_amplitude_i (wr_amplitude_i),
        .wr_duration_i  (wr_duration_i),
        .rd_addr_i      (idx_q),
        .rd_waveform_o  (tbl_wf),
        .rd_phase_o     (tbl_ph),
        .rd_amplitude_o (tbl_am),
        .rd_duration_o  (tbl_dur)
    );

    // State, index, sample counter and the latched copy of the running entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dur_q   <= '0;
            ph_q    <= '0;
            am_q    <= '0;
            wf_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            ph_q    <= ph_d;
            am_q    <= am_d;
            wf_q    <= wf_d;
        end
    end

    // Next-state logic, including the end-of-list decision folded into FETCH/RUN exits.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        ph_d    = ph_q;
        am_d    = am_q;
        wf_d    = wf_q;
        finish  = 1'b0;
        if (stop_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_FETCH;
                        idx_d   = '0;
                    end
                end
                ST_FETCH: begin
                    wf_d  = tbl_wf;
                    ph_d  = tbl_ph;
                    am_d  = tbl_am;
                    dur_d = tbl_dur;
                    if (tbl_dur == '0) begin
                        // Empty entry 0 ends the list even when looping, so it can never spin.
                        if (loop_i && (idx_q != '0)) begin
                            idx_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                            finish  = 1'b1;
                        end
                    end else begin
                        state_d = ST_SET_PH;
                    end
                end
                ST_SET_PH: state_d = ST_SET_AM;
                ST_SET_AM: state_d = ST_RUN;
                ST_RUN: begin
                    if (sample_valid_i) begin
                        if (cnt_q == dur_q - DUR_W'(1)) begin
                            cnt_d = '0;
                            if (idx_q == LAST_IDX) begin
                                if (loop_i) begin
                                    idx_d   = '0;
                                    state_d = ST_FETCH;
                                end else begin
                                    state_d = ST_IDLE;
                                    finish  = 1'b1;
                                end
                            end else begin
                                idx_d   = idx_q + ADDR_W'(1);
                                state_d = ST_FETCH;
                            end
                        end else begin
                            cnt_d = cnt_q + DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state so the outputs can be registered.
    always_comb begin
        enable_d = (state_d == ST_RUN);
        phs_d    = (state_d == ST_SET_PH);
        ams_d    = (state_d == ST_SET_AM);
        busy_d   = (state_d != ST_IDLE);
        done_d   = finish;
        data_d   = data_q;
        wave_d   = wave_q;
        if (phs_d) begin
            data_d = ph_d;
        end else if (ams_d) begin
            data_d = am_q;
        end
        if ((state_q == ST_SET_AM) && (state_d == ST_RUN)) begin
            wave_d = wf_q;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q <= 1'b0;
            phs_q    <= 1'b0;
            ams_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            wave_q   <= '0;
        end else begin
            enable_q <= enable_d;
            phs_q    <= phs_d;
            ams_q    <= ams_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            wave_q   <= wave_d;
        end
    end

    assign enable_o           = enable_q;
    assign waveform_o         = wave_q;
    assign set_phase_strobe_o = phs_q;
    assign set_ampl_strobe_o  = ams_q;
    assign data_o             = data_q;
    assign busy_o             = busy_q;
    assign entry_idx_o        = idx_q;
    assign done_strobe_o      = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed scenarios plus random playlists walked by a table model.
module tb_wave_sequencer;
    import wave_seq_pkg::*;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, wr_en, start, stop, loop_en, sv;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_wf;
    logic [7:0]    wr_ph, wr_am;
    logic [15:0]   wr_dur;
    logic          enable, phs, ams, busy, done;
    logic [1:0]    waveform;
    logic [7:0]    data;
    logic [AW-1:0] entry_idx;

    entry_t model [N];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wave_sequencer dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .wr_en_i            (wr_en),
        .wr_addr_i          (wr_addr),
        .wr_waveform_i      (wr_wf),
        .wr_phase_i         (wr_ph),
        .wr_amplitude_i     (wr_am),
        .wr_duration_i      (wr_dur),
        .start_i            (start),
        .stop_i             (stop),
        .loop_i             (loop_en),
        .sample_valid_i     (sv),
        .enable_o           (enable),
        .waveform_o         (waveform),
        .set_phase_strobe_o (phs),
        .set_ampl_strobe_o  (ams),
        .data_o             (data),
        .busy_o             (busy),
        .entry_idx_o        (entry_idx),
        .done_strobe_o      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int i, input logic [1:0] wf, input logic [7:0] ph,
                               input logic [7:0] am, input logic [15:0] dur);
        wr_addr = AW'(i);
        wr_wf   = wf;
        wr_ph   = ph;
        wr_am   = am;
        wr_dur  = dur;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        model[i] = '{waveform: wf, phase: ph, amplitude: am, duration: dur};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, enable, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_strobes"}, {phs, ams}, 0);
    endtask

    // One entry: strobes, then enable held for exactly 'duration' accepted samples.
    task automatic visit(input int i, input int stop_after, input logic rewrite,
                         input entry_t new_e, output logic aborted);
        entry_t e;
        int     pulses;
        int     cyc;
        logic   svl;
        e       = model[i];
        pulses  = 0;
        cyc     = 0;
        aborted = 1'b0;
        sv = 1'($urandom_range(0, 1));
        tick();
        chk("ph_strobe", phs, 1);
        chk("ph_data", data, e.phase);
        chk("ph_idx", entry_idx, i);
        chk("ph_en", {enable, ams}, 0);
        sv = 1'($urandom_range(0, 1));
        tick();
        chk("am_strobe", ams, 1);
        chk("am_data", data, e.amplitude);
        chk("am_en", {enable, phs}, 0);
        sv = 1'($urandom_range(0, 1));
        tick();
        chk("run_start_en", enable, 1);
        chk("run_start_wave", waveform, e.waveform);
        while (1) begin
            if (stop_after > 0 && pulses == stop_after) begin
                stop  = 1'b1;
                start = 1'b1;
                sv    = 1'b1;
                tick();
                stop  = 1'b0;
                start = 1'b0;
                chk_quiet("stop");
                for (int k = 0; k < 3; k++) begin
                    sv = 1'($urandom_range(0, 1));
                    tick();
                    chk_quiet("stop_hold");
                end
                aborted = 1'b1;
                return;
            end
            svl = 1'($urandom_range(0, 1));
            sv  = svl;
            if (rewrite && pulses == 1) begin
                wr_addr = '0;
                wr_wf   = new_e.waveform;
                wr_ph   = new_e.phase;
                wr_am   = new_e.amplitude;
                wr_dur  = new_e.duration;
                wr_en   = 1'b1;
            end
            tick();
            if (wr_en) begin
                wr_en    = 1'b0;
                model[0] = new_e;
                rewrite  = 1'b0;
            end
            if (svl) pulses++;
            if (pulses == int'(e.duration)) begin
                chk("run_end_en", enable, 0);
                chk("run_end_data_hold", data, e.amplitude);
                return;
            end
            chk("run_en", enable, 1);
            chk("run_wave", waveform, e.waveform);
            chk("run_data_hold", data, e.amplitude);
            cyc++;
            if (cyc > 400) begin
                chk("run_timeout_pulses", pulses, e.duration);
                aborted = 1'b1;
                return;
            end
        end
    endtask

    // Walks the playlist the way the model table dictates and checks every transition.
    task automatic run_seq(input logic lp, input int max_visits, input int stop_after,
                           input logic rewrite, input entry_t new_e);
        int   cur;
        int   visits;
        int   guard;
        logic ab;
        cur     = 0;
        visits  = 0;
        loop_en = lp;
        sv      = 1'($urandom_range(0, 1));
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (guard = 0; guard < 100; guard++) begin
            chk("fetch_busy", busy, 1);
            chk("fetch_idx", entry_idx, cur);
            chk("fetch_en", enable, 0);
            chk("fetch_done", done, 0);
            chk("fetch_strobes", {phs, ams}, 0);
            if (lp && visits >= max_visits) begin
                stop  = 1'b1;
                start = 1'b1;
                tick();
                stop  = 1'b0;
                start = 1'b0;
                chk_quiet("loop_stop");
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk_quiet("loop_stop_hold");
                end
                return;
            end
            if (model[cur].duration == 0) begin
                sv = 1'($urandom_range(0, 1));
                tick();
                if (lp && cur != 0) begin
                    cur = 0;
                    continue;
                end
                chk("marker_done", done, 1);
                chk("marker_busy", busy, 0);
                chk("marker_en", enable, 0);
                tick();
                chk("marker_done_pulse", done, 0);
                chk("marker_idle", busy, 0);
                return;
            end
            visit(cur, (visits == 0) ? stop_after : 0, rewrite && (visits == 0) && (cur == 0),
                  new_e, ab);
            if (ab) return;
            visits++;
            if (cur == N - 1) begin
                if (lp) begin
                    cur = 0;
                end else begin
                    chk("last_done", done, 1);
                    chk("last_busy", busy, 0);
                    tick();
                    chk("last_done_pulse", done, 0);
                    chk("last_idle", busy, 0);
                    return;
                end
            end else begin
                cur++;
            end
        end
        chk("seq_guard", guard, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        entry_t ne;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sv = 1'b0;
        wr_addr = '0; wr_wf = '0; wr_ph = '0; wr_am = '0; wr_dur = '0;
        for (int i = 0; i < N; i++) model[i] = '0;
        tick();
        tick();
        chk("reset_outs", {enable, waveform, phs, ams, data, busy, entry_idx, done}, 0);
        rst = 1'b0;
        tick();
        chk("reset_hold", {enable, busy, done}, 0);

        // Single entry followed by an end marker.
        write_entry(0, WAVE_SINE, 8'h10, 8'h80, 16'd4);
        write_entry(1, WAVE_SQUARE, 8'h22, 8'h33, 16'd0);
        run_seq(1'b0, 0, 0, 1'b0, '0);

        // Full table, no loop, then looping with a stop.
        for (int i = 0; i < N; i++)
            write_entry(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 16'd2);
        run_seq(1'b0, 0, 0, 1'b0, '0);
        run_seq(1'b1, 11, 0, 1'b0, '0);

        // Stop (with start) one sample into a four-sample entry.
        write_entry(0, WAVE_TRIANGLE, 8'h5A, 8'hA5, 16'd4);
        write_entry(1, WAVE_SINE, 8'h00, 8'h00, 16'd0);
        run_seq(1'b0, 0, 1, 1'b0, '0);

        // Rewrite entry 0 while it runs; the new values show up on the next pass.
        write_entry(0, WAVE_SAW, 8'h11, 8'h22, 16'd3);
        write_entry(1, WAVE_SQUARE, 8'h33, 8'h44, 16'd2);
        write_entry(2, WAVE_SINE, 8'h00, 8'h00, 16'd0);
        ne = '{waveform: WAVE_TRIANGLE, phase: 8'h99, amplitude: 8'h77, duration: 16'd5};
        run_seq(1'b1, 5, 0, 1'b1, ne);

        // Looping over an empty list terminates with a done pulse.
        write_entry(0, WAVE_SINE, 8'h01, 8'h02, 16'd0);
        run_seq(1'b1, 4, 0, 1'b0, '0);

        // Random playlists.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                write_entry(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                            16'(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3)));
            run_seq(1'($urandom_range(0, 1)), 9, 0, 1'b0, '0);
        end

        // Reset during the phase strobe clears outputs and the table.
        write_entry(0, WAVE_SQUARE, 8'h42, 8'h24, 16'd5);
        loop_en = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        chk("pre_reset_ph_strobe", phs, 1);
        rst = 1'b1;
        tick();
        chk("mid_reset_outs", {enable, waveform, phs, ams, data, busy, entry_idx, done}, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        run_seq(1'b0, 0, 0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
